pll_acq_ctrl: RTL and testbench

Acquisition/lock sequencer for the PLL loop filter. It watches the same `phase_valid`/`phase_err` stream the loop filter consumes and drives the filter's enable and integrator clear. It also drives a gain-schedule select (wide → medium → narrow) and a lock indication. It sits beside the loop filter in the PLL top, between the phase detector and the NCO control path.

---
 rtl/pll_pkg.sv | 35 +++
 rtl/pll_acq_ctrl_err_window.sv | 21 ++
 rtl/pll_acq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pll_acq_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_pkg.sv
// Shared definitions for the PLL acquisition sequencer: state codes, gain codes,
// default lock threshold and the registered control bundle driven by each state.
package pll_pkg;

    localparam int unsigned LOCK_THR_DEF = 256;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_ACQ    = 3'd2,
        S_SETTLE = 3'd3,
        S_TRACK  = 3'd4
    } state_e;

    localparam logic [1:0] GAIN_WIDE   = 2'd0;
    localparam logic [1:0] GAIN_MED    = 2'd1;
    localparam logic [1:0] GAIN_NARROW = 2'd2;

    typedef struct packed {
        logic       filt_ena;
        logic [1:0] gain_sel;
        logic       locked;
    } ctl_t;

    // Loop-filter controls that hold for the whole time a state is occupied.
    function automatic ctl_t ctl_of(input state_e s);
        ctl_t c;
        c.filt_ena = (s == S_ACQ) || (s == S_SETTLE) || (s == S_TRACK);
        c.gain_sel = (s == S_SETTLE) ? GAIN_MED :
                     (s == S_TRACK)  ? GAIN_NARROW : GAIN_WIDE;
        c.locked   = (s == S_TRACK);
        return c;
    endfunction

endpackage

// File: rtl/pll_acq_ctrl_err_window.sv
// Combinational |phase error| <= threshold test; magnitude is taken one bit wider
// so the most negative code never aliases into the window.
module err_window #(
    parameter int unsigned ERR_W    = 18,
    parameter int unsigned LOCK_THR = 256
) (
    input  logic [ERR_W-1:0] i_err,
    output logic             o_in_win_c
);

    localparam logic [ERR_W:0] ONE = (ERR_W + 1)'(1);
    localparam logic [ERR_W:0] THR = (ERR_W + 1)'(LOCK_THR);

    logic [ERR_W:0] w_ext;
    logic [ERR_W:0] w_mag;

    assign w_ext      = {i_err[ERR_W-1], i_err};
    assign w_mag      = i_err[ERR_W-1] ? ((~w_ext) + ONE) : w_ext;
    assign o_in_win_c = (w_mag <= THR);

endmodule

// File: rtl/pll_acq_ctrl.sv
// Acquisition/lock sequencer beside the PLL loop filter: walks IDLE->CLEAR->ACQ->
// SETTLE->TRACK on the phase-error stream and drives filter enable/clear, gain and lock.
module pll_acq_ctrl
    import pll_pkg::*;
#(
    parameter int unsigned ERR_W       = 18,
    parameter int unsigned LOCK_THR    = LOCK_THR_DEF,
    parameter int unsigned LOCK_CNT    = 64,
    parameter int unsigned SETTLE_CNT  = 16,
    parameter int unsigned UNLOCK_CNT  = 8,
    parameter int unsigned ACQ_TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_ena,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_phase_valid,
    input  logic [ERR_W-1:0] i_phase_err,
    output logic             o_filt_ena,
    output logic             o_filt_clr,
    output logic [1:0]       o_gain_sel,
    output logic             o_locked,
    output logic             o_timeout,
    output logic [2:0]       o_state
);

    localparam int unsigned WIN_MAX = (LOCK_CNT > SETTLE_CNT) ? LOCK_CNT : SETTLE_CNT;
    localparam int unsigned WIN_W   = $clog2(WIN_MAX + 1);
    localparam int unsigned OUT_W   = $clog2(UNLOCK_CNT + 1);
    localparam int unsigned ACQ_W   = $clog2(ACQ_TIMEOUT + 1);

    localparam logic [WIN_W-1:0] WIN_MAX_V = WIN_W'(WIN_MAX);
    localparam logic [WIN_W-1:0] LOCK_V    = WIN_W'(LOCK_CNT);
    localparam logic [WIN_W-1:0] SETTLE_V  = WIN_W'(SETTLE_CNT);
    localparam logic [OUT_W-1:0] UNLOCK_V  = OUT_W'(UNLOCK_CNT);
    localparam logic [ACQ_W-1:0] TMO_V     = ACQ_W'(ACQ_TIMEOUT);

    state_e           r_state;
    ctl_t             r_ctl;
    logic             r_filt_clr;
    logic             r_timeout;
    logic [WIN_W-1:0] r_win_cnt;
    logic [OUT_W-1:0] r_out_cnt;
    logic [ACQ_W-1:0] r_acq_cnt;

    logic             w_in_win;
    logic [WIN_W-1:0] w_win_inc;
    logic [OUT_W-1:0] w_out_inc;
    logic [ACQ_W-1:0] w_acq_inc;

    err_window #(
        .ERR_W    (ERR_W),
        .LOCK_THR (LOCK_THR)
    ) u_err_window (
        .i_err      (i_phase_err),
        .o_in_win_c (w_in_win)
    );

    // Saturating increments; the FSM never lets a counter sit at its max, but never wrap anyway.
    assign w_win_inc = (r_win_cnt == WIN_MAX_V) ? r_win_cnt : r_win_cnt + WIN_W'(1);
    assign w_out_inc = (r_out_cnt == UNLOCK_V)  ? r_out_cnt : r_out_cnt + OUT_W'(1);
    assign w_acq_inc = (r_acq_cnt == TMO_V)     ? r_acq_cnt : r_acq_cnt + ACQ_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ctl      <= ctl_of(S_IDLE);
            r_filt_clr <= 1'b0;
            r_timeout  <= 1'b0;
            r_win_cnt  <= '0;
            r_out_cnt  <= '0;
            r_acq_cnt  <= '0;
        end else if (!i_ena) begin
            r_filt_clr <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_filt_clr <= 1'b0;
            r_timeout  <= 1'b0;
            if (i_stop) begin
                r_state   <= S_IDLE;
                r_ctl     <= ctl_of(S_IDLE);
                r_win_cnt <= '0;
                r_out_cnt <= '0;
                r_acq_cnt <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            r_state    <= S_CLEAR;
                            r_ctl      <= ctl_of(S_CLEAR);
                            r_filt_clr <= 1'b1;
                        end
                    end
                    S_CLEAR: begin
                        r_state   <= S_ACQ;
                        r_ctl     <= ctl_of(S_ACQ);
                        r_win_cnt <= '0;
                        r_out_cnt <= '0;
                        r_acq_cnt <= '0;
                    end
                    S_ACQ: begin
                        if (i_phase_valid) begin
                            r_acq_cnt <= w_acq_inc;
                            // Lock takes precedence over a timeout on the same sample.
                            if (w_in_win && (w_win_inc == LOCK_V)) begin
                                r_state   <= S_SETTLE;
                                r_ctl     <= ctl_of(S_SETTLE);
                                r_win_cnt <= '0;
                            end else if (w_acq_inc == TMO_V) begin
                                r_state    <= S_CLEAR;
                                r_ctl      <= ctl_of(S_CLEAR);
                                r_filt_clr <= 1'b1;
                                r_timeout  <= 1'b1;
                                r_win_cnt  <= '0;
                                r_out_cnt  <= '0;
                                r_acq_cnt  <= '0;
                            end else begin
                                r_win_cnt <= w_in_win ? w_win_inc : '0;
                            end
                        end
                    end
                    S_SETTLE: begin
                        if (i_phase_valid) begin
                            if (!w_in_win) begin
                                r_state   <= S_ACQ;
                                r_ctl     <= ctl_of(S_ACQ);
                                r_win_cnt <= '0;
                                r_acq_cnt <= '0;
                            end else if (w_win_inc == SETTLE_V) begin
                                r_state   <= S_TRACK;
                                r_ctl     <= ctl_of(S_TRACK);
                                r_win_cnt <= '0;
                                r_out_cnt <= '0;
                            end else begin
                                r_win_cnt <= w_win_inc;
                            end
                        end
                    end
                    S_TRACK: begin
                        if (i_phase_valid) begin
                            if (w_in_win) begin
                                r_out_cnt <= '0;
                            end else if (w_out_inc == UNLOCK_V) begin
                                r_state    <= S_CLEAR;
                                r_ctl      <= ctl_of(S_CLEAR);
                                r_filt_clr <= 1'b1;
                                r_win_cnt  <= '0;
                                r_out_cnt  <= '0;
                                r_acq_cnt  <= '0;
                            end else begin
                                r_out_cnt <= w_out_inc;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_ctl   <= ctl_of(S_IDLE);
                    end
                endcase
            end
        end
    end

    assign o_filt_ena = r_ctl.filt_ena;
    assign o_gain_sel = r_ctl.gain_sel;
    assign o_locked   = r_ctl.locked;
    assign o_filt_clr = r_filt_clr;
    assign o_timeout  = r_timeout;
    assign o_state    = r_state;

endmodule

// File: tb/tb_pll_acq_ctrl.sv
// Bench for pll_acq_ctrl: directed scenarios against fixed expectations, then a
// randomized run against an integer-arithmetic reference model of the sequencer.
module tb_pll_acq_ctrl;

    localparam int ERR_W = 18;

    logic             clk;
    logic             rst_n;
    logic             i_ena;
    logic             i_start;
    logic             i_stop;
    logic             i_phase_valid;
    logic [ERR_W-1:0] i_phase_err;
    logic             o_filt_ena;
    logic             o_filt_clr;
    logic [1:0]       o_gain_sel;
    logic             o_locked;
    logic             o_timeout;
    logic [2:0]       o_state;

    int n_cmp;
    int n_err;

    // Reference model: phase number and plain integer counters.
    int m_st, m_win, m_out, m_acq;
    bit m_clr, m_tmo;

    pll_acq_ctrl #(
        .ERR_W       (ERR_W),
        .LOCK_THR    (100),
        .LOCK_CNT    (4),
        .SETTLE_CNT  (2),
        .UNLOCK_CNT  (2),
        .ACQ_TIMEOUT (10)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_ena         (i_ena),
        .i_start       (i_start),
        .i_stop        (i_stop),
        .i_phase_valid (i_phase_valid),
        .i_phase_err   (i_phase_err),
        .o_filt_ena    (o_filt_ena),
        .o_filt_clr    (o_filt_clr),
        .o_gain_sel    (o_gain_sel),
        .o_locked      (o_locked),
        .o_timeout     (o_timeout),
        .o_state       (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector: {state, filt_ena, filt_clr, gain_sel, locked, timeout}
    logic [8:0] w_obs;
    assign w_obs = {o_state, o_filt_ena, o_filt_clr, o_gain_sel, o_locked, o_timeout};

    localparam logic [8:0] V_IDLE   = {3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    localparam logic [8:0] V_CLEAR  = {3'd1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
    localparam logic [8:0] V_CLRTMO = {3'd1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1};
    localparam logic [8:0] V_ACQ    = {3'd2, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
    localparam logic [8:0] V_SETTLE = {3'd3, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0};
    localparam logic [8:0] V_TRACK  = {3'd4, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0};

    function automatic logic [8:0] model_vec();
        logic [1:0] g;
        g = (m_st == 3) ? 2'd1 : (m_st == 4) ? 2'd2 : 2'd0;
        return {3'(m_st), (m_st >= 2), m_clr, g, (m_st == 4), m_tmo};
    endfunction

    task automatic model_reset();
        m_st = 0; m_win = 0; m_out = 0; m_acq = 0; m_clr = 0; m_tmo = 0;
    endtask

    task automatic model_step(input bit e, input bit s, input bit p, input bit v, input int err);
        bit iw;
        iw = ((err < 0) ? -err : err) <= 100;
        if (!e) begin
            m_clr = 0; m_tmo = 0;
            return;
        end
        m_clr = 0; m_tmo = 0;
        if (p) begin
            m_st = 0; m_win = 0; m_out = 0; m_acq = 0;
            return;
        end
        case (m_st)
            0: if (s) begin m_st = 1; m_clr = 1; end
            1: begin m_st = 2; m_win = 0; m_out = 0; m_acq = 0; end
            2: if (v) begin
                m_acq = (m_acq < 10) ? m_acq + 1 : 10;
                m_win = iw ? m_win + 1 : 0;
                if (m_win >= 4) begin
                    m_st = 3; m_win = 0;
                end else if (m_acq >= 10) begin
                    m_st = 1; m_tmo = 1; m_clr = 1; m_win = 0; m_out = 0; m_acq = 0;
                end
            end
            3: if (v) begin
                if (iw) begin
                    m_win++;
                    if (m_win >= 2) begin m_st = 4; m_win = 0; m_out = 0; end
                end else begin
                    m_st = 2; m_win = 0; m_acq = 0;
                end
            end
            4: if (v) begin
                if (iw) m_out = 0;
                else begin
                    m_out++;
                    if (m_out >= 2) begin m_st = 1; m_clr = 1; m_win = 0; m_out = 0; m_acq = 0; end
                end
            end
            default: m_st = 0;
        endcase
    endtask

    // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
    task automatic tick(input bit e, input bit s, input bit p, input bit v, input int err);
        i_ena = e; i_start = s; i_stop = p; i_phase_valid = v;
        i_phase_err = ERR_W'(err);
        model_step(e, s, p, v, err);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_ena = 0; i_start = 0; i_stop = 0; i_phase_valid = 0; i_phase_err = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (w_obs !== V_IDLE) begin
            n_err++; $display("FAIL reset: got %b want %b", w_obs, V_IDLE);
        end
        rst_n = 1'b1;
        model_reset();
        tick(1, 0, 0, 1, 50);
        n_cmp++;
        if (w_obs !== V_IDLE) begin
            n_err++; $display("FAIL idle_no_start: got %b want %b", w_obs, V_IDLE);
        end
    endtask

    task automatic test_lock_seq();
        tick(1, 1, 0, 0, 0);
        n_cmp++;
        if (w_obs !== V_CLEAR) begin
            n_err++; $display("FAIL start_clear: got %b want %b", w_obs, V_CLEAR);
        end
        tick(1, 0, 0, 0, 0);
        n_cmp++;
        if (w_obs !== V_ACQ) begin
            n_err++; $display("FAIL clear_to_acq: got %b want %b", w_obs, V_ACQ);
        end
        repeat (3) tick(1, 0, 0, 1, 50);
        n_cmp++;
        if (w_obs !== V_ACQ) begin
            n_err++; $display("FAIL acq_3_samples: got %b want %b", w_obs, V_ACQ);
        end
        tick(1, 0, 0, 1, 50);
        n_cmp++;
        if (w_obs !== V_SETTLE) begin
            n_err++; $display("FAIL acq_to_settle: got %b want %b", w_obs, V_SETTLE);
        end
        tick(1, 0, 0, 1, -100);
        n_cmp++;
        if (w_obs !== V_SETTLE) begin
            n_err++; $display("FAIL settle_1_sample: got %b want %b", w_obs, V_SETTLE);
        end
        tick(1, 0, 0, 1, -100);
        n_cmp++;
        if (w_obs !== V_TRACK) begin
            n_err++; $display("FAIL settle_to_track: got %b want %b", w_obs, V_TRACK);
        end
    endtask

    task automatic test_unlock();
        int errs[4] = '{200, 0, 200, 200};
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 0, 1, errs[i]);
            n_cmp++;
            if (w_obs !== V_TRACK) begin
                n_err++; $display("FAIL track_hold_%0d: got %b want %b", i, w_obs, V_TRACK);
            end
        end
        tick(1, 0, 0, 1, errs[3]);
        n_cmp++;
        if (w_obs !== V_CLEAR) begin
            n_err++; $display("FAIL unlock_clear: got %b want %b", w_obs, V_CLEAR);
        end
        tick(1, 0, 0, 0, 0);
        n_cmp++;
        if (w_obs !== V_ACQ) begin
            n_err++; $display("FAIL unlock_reacq: got %b want %b", w_obs, V_ACQ);
        end
    endtask

    task automatic test_settle_fail();
        repeat (4) tick(1, 0, 0, 1, 50);
        tick(1, 0, 0, 1, 101);
        n_cmp++;
        if (w_obs !== V_ACQ) begin
            n_err++; $display("FAIL settle_fail: got %b want %b", w_obs, V_ACQ);
        end
        repeat (3) tick(1, 0, 0, 1, -37);
        n_cmp++;
        if (w_obs !== V_ACQ) begin
            n_err++; $display("FAIL relock_early: got %b want %b", w_obs, V_ACQ);
        end
        tick(1, 0, 0, 1, 100);
        n_cmp++;
        if (w_obs !== V_SETTLE) begin
            n_err++; $display("FAIL relock_4th: got %b want %b", w_obs, V_SETTLE);
        end
        tick(1, 0, 0, 1, -101);
    endtask

    task automatic test_timeout();
        // 3 in-window then the most negative code; it must not complete a lock.
        repeat (3) tick(1, 0, 0, 1, 50);
        tick(1, 0, 0, 1, -131072);
        n_cmp++;
        if (w_obs !== V_ACQ) begin
            n_err++; $display("FAIL min_err_out_of_window: got %b want %b", w_obs, V_ACQ);
        end
        tick(1, 0, 0, 0, 0);
        repeat (5) tick(1, 0, 0, 1, 500);
        n_cmp++;
        if (w_obs !== V_ACQ) begin
            n_err++; $display("FAIL acq_9_samples: got %b want %b", w_obs, V_ACQ);
        end
        tick(1, 0, 0, 1, -500);
        n_cmp++;
        if (w_obs !== V_CLRTMO) begin
            n_err++; $display("FAIL timeout_pulse: got %b want %b", w_obs, V_CLRTMO);
        end
        tick(1, 0, 0, 0, 0);
        n_cmp++;
        if (w_obs !== V_ACQ) begin
            n_err++; $display("FAIL timeout_reacq: got %b want %b", w_obs, V_ACQ);
        end
    endtask

    task automatic test_ena_freeze();
        repeat (6) tick(1, 0, 0, 1, 10);
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0, 1, 500);
            n_cmp++;
            if (w_obs !== V_TRACK) begin
                n_err++; $display("FAIL ena_low_%0d: got %b want %b", i, w_obs, V_TRACK);
            end
        end
        tick(1, 0, 0, 1, 500);
        n_cmp++;
        if (w_obs !== V_TRACK) begin
            n_err++; $display("FAIL ena_low_no_count: got %b want %b", w_obs, V_TRACK);
        end
    endtask

    task automatic test_stop_track();
        tick(1, 0, 1, 1, 0);
        n_cmp++;
        if (w_obs !== V_IDLE) begin
            n_err++; $display("FAIL stop_track: got %b want %b", w_obs, V_IDLE);
        end
    endtask

    task automatic test_start_stop();
        tick(1, 1, 1, 0, 0);
        n_cmp++;
        if (w_obs !== V_IDLE) begin
            n_err++; $display("FAIL start_and_stop: got %b want %b", w_obs, V_IDLE);
        end
        tick(0, 1, 0, 0, 0);
        n_cmp++;
        if (w_obs !== V_IDLE) begin
            n_err++; $display("FAIL start_ena_low: got %b want %b", w_obs, V_IDLE);
        end
    endtask

    task automatic test_reset_mid();
        tick(1, 1, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        repeat (4) tick(1, 0, 0, 1, 50);
        n_cmp++;
        if (w_obs !== V_SETTLE) begin
            n_err++; $display("FAIL pre_reset_settle: got %b want %b", w_obs, V_SETTLE);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (w_obs !== V_IDLE) begin
            n_err++; $display("FAIL async_reset: got %b want %b", w_obs, V_IDLE);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        tick(1, 0, 0, 1, 50);
        n_cmp++;
        if (w_obs !== V_IDLE) begin
            n_err++; $display("FAIL no_auto_restart: got %b want %b", w_obs, V_IDLE);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            bit e, s, p, v;
            int err;
            logic signed [ERR_W-1:0] raw;
            logic [8:0] exp_v;
            e = ($urandom_range(99) < 92);
            s = ($urandom_range(99) < 10);
            p = ($urandom_range(999) < 8);
            v = ($urandom_range(99) < 75);
            case ($urandom_range(9))
                0, 1:    begin raw = ERR_W'($urandom); err = int'(raw); end
                2:       err = -131072;
                3:       err = ($urandom_range(1) != 0) ? 101 : -101;
                default: err = int'($urandom_range(200)) - 100;
            endcase
            tick(e, s, p, v, err);
            exp_v = model_vec();
            n_cmp++;
            if (w_obs !== exp_v) begin
                n_err++;
                $display("FAIL random_%0d: got %b want %b (e=%0b s=%0b p=%0b v=%0b err=%0d)",
                         n, w_obs, exp_v, e, s, p, v, err);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        model_reset();
        test_reset();
        test_lock_seq();
        test_unlock();
        test_settle_fail();
        test_timeout();
        test_ena_freeze();
        test_stop_track();
        test_start_stop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
